// File: rtl/mem_pkg.sv
// Shared constants and helpers for the pipelined memory slice.
// Contents:
//   RD_LAT_MIN / RD_LAT_MAX : legal range of the read-latency parameter
//   XWR_CNT_W               : width of the saturating X-write counter
//   mem_bytes(data_w)       : BYTES, number of byte lanes in a data word
//   mem_off_w(data_w)       : OFF_W, number of byte-offset address bits
package mem_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned XWR_CNT_W  = 8;

  // BYTES = DATA_W / 8
  function automatic int unsigned mem_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // OFF_W = log2(BYTES); zero for byte-wide memories
  function automatic int unsigned mem_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO, registered pointers, head visible on rdata.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, wdata  : enqueue wdata (ignored when full)
//   pop          : dequeue the head (ignored when empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags
module rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = storage[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth need not be a power of two, so pointers wrap explicitly.
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data-path only and needs no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      storage[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pipelined_memory.sv
// Byte-addressed, word-organised memory with a valid/ready request port and
// an in-order valid/ready response port.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_valid, req_ready  : request handshake
//   req_wr                : 1 = write, 0 = read
//   req_addr, req_wdata   : byte address and write data
//   req_be                : byte-lane write enables
//   rsp_valid, rsp_ready  : response handshake
//   rsp_rdata, rsp_err    : read data (0 for writes/errors) and error flag
//   xwr_cnt               : saturating count of writes with X/Z on enabled lanes
// A response is presented during the RD_LAT-th cycle after its accepting edge
// and is consumed on the edge that closes that cycle when rsp_ready is high,
// so a steady stream sustains one request per cycle.
module pipelined_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [XWR_CNT_W-1:0]   xwr_cnt
);

  localparam int unsigned BYTES      = mem_bytes(DATA_W);
  localparam int unsigned OFF_W      = mem_off_w(DATA_W);
  localparam int unsigned MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FIFO_DEPTH = RD_LAT + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              wr_ok;
  logic              rd_ok;

  assign accept       = req_valid && req_ready && !reset;
  assign word_idx     = req_addr >> OFF_W;
  assign mem_idx      = MEM_AW'(word_idx);
  assign misaligned   = (req_addr & ADDR_W'(BYTES - 1)) != '0;
  assign out_of_range = 64'(word_idx) >= 64'(DEPTH);
  assign req_err      = misaligned || out_of_range;
  assign wr_ok        = accept && req_wr && !req_err;
  assign rd_ok        = accept && !req_wr && !req_err;

  // ---------------------------------------------------------------------------
  // Memory array (simulation model). Never reset, so contents survive reset.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: the read is sampled at the accepting edge into stage 0.
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0] pipe_valid_q;
  logic [RD_LAT-1:0] pipe_err_q;
  logic [DATA_W-1:0] pipe_data_q [RD_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid_q <= '0;
    end else begin
      pipe_valid_q[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    pipe_data_q[0] <= rd_ok ? mem[mem_idx] : '0;
    pipe_err_q[0]  <= req_err;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_err_q[i]  <= pipe_err_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO with bypass: when it is empty the last pipeline stage is
  // presented directly and only parked in the FIFO if not taken this cycle.
  // ---------------------------------------------------------------------------
  logic              last_valid;
  logic [DATA_W:0]   last_entry;
  logic [DATA_W:0]   fifo_rdata;
  logic [DATA_W:0]   head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rsp_fire;

  assign last_valid = pipe_valid_q[RD_LAT-1];
  assign last_entry = {pipe_err_q[RD_LAT-1], pipe_data_q[RD_LAT-1]};
  assign fifo_push  = last_valid && !(fifo_empty && rsp_ready);
  assign fifo_pop   = !fifo_empty && rsp_ready;
  assign head       = fifo_empty ? last_entry : fifo_rdata;
  assign rsp_valid  = !fifo_empty || last_valid;
  assign rsp_rdata  = rsp_valid ? head[DATA_W-1:0] : '0;
  assign rsp_err    = rsp_valid && head[DATA_W];
  assign rsp_fire   = rsp_valid && rsp_ready;

  rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (last_entry),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Outstanding count (pipeline + FIFO). Capping it at the FIFO depth means
  // every in-flight request always has a FIFO slot, and req_ready depends on
  // registered state only.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] outstanding_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, rsp_fire})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign req_ready = outstanding_q < CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // X/Z write detection (simulation model). Synthesis sees a constant 0 hit.
  // ---------------------------------------------------------------------------
  logic xwr_hit;

  always_comb begin
    xwr_hit = 1'b0;
`ifndef SYNTHESIS
    if (wr_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be[b] && $isunknown(req_wdata[b*8 +: 8])) begin
          xwr_hit = 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xwr_cnt <= '0;
    end else if (xwr_hit && (xwr_cnt != '1)) begin
      xwr_cnt <= xwr_cnt + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (xwr_hit) begin
      $display("%0t pipelined_memory: X/Z write data at address 0x%0h", $time, req_addr);
    end
  end

  fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(fifo_push && fifo_full));
`endif

endmodule

// File: tb/tb_pipelined_memory.sv
// Self-checking bench for pipelined_memory: directed scenarios plus random
// traffic compared against a word-array reference model and an expected
// response queue.
module tb_pipelined_memory;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;
  localparam logic [31:0] REGION = 32'h100;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  xwr_cnt;

  always #5 clock = ~clock;

  pipelined_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .xwr_cnt   (xwr_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Reference: word index = addr/4, error if unaligned or beyond DEPTH words.
  function automatic rsp_t model_accept(input logic wr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be);
    rsp_t        r;
    int unsigned idx;
    idx     = addr / 4;
    r.err   = (addr % 4 != 0) || (idx >= DEPTH);
    r.rdata = '0;
    r.cyc   = cyc;
    if (!r.err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        r.rdata = model_mem[idx];
      end
    end
    return r;
  endfunction

  // One clock cycle: drive at negedge, observe handshakes just before posedge.
  task automatic drive(input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic rr,
                       output logic acc);
    rsp_t g;
    @(negedge clock);
    req_valid = v;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = rr;
    #1;
    acc = !reset && req_valid && req_ready;
    if (!reset && rsp_valid && rsp_ready) begin
      g.rdata = rsp_rdata;
      g.err   = rsp_err;
      g.cyc   = cyc;
      got_q.push_back(g);
    end
    if (acc) exp_q.push_back(model_accept(wr, addr, wdata, be));
    @(posedge clock);
    cyc++;
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return REGION + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
    if (sel == 1) return 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
    return REGION + 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic test_reset();
    logic acc;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h0BAD0BAD;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_cmp++; if (xwr_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_xwr_cnt: got %0d want 0", xwr_cnt); end
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    exp_q.delete();
    got_q.delete();
    repeat (RD_LAT + 4) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_ignored_req: got %0d responses want 0", got_q.size()); end
  endtask

  task automatic test_basic();
    logic acc;
    exp_q.delete();
    got_q.delete();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, acc);
    drain(20);
    drive(1'b1, 1'b0, 32'h10, '0, '0, 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++; $display("FAIL basic_count: got %0d responses want 2", got_q.size());
    end else begin
      n_cmp++; if (got_q[0].rdata !== 32'h0 || got_q[0].err !== 1'b0) begin
        n_fail++; $display("FAIL basic_write_rsp: got %h/%b want 00000000/0", got_q[0].rdata, got_q[0].err);
      end
      n_cmp++; if (got_q[1].rdata !== 32'hDEADBEEF || got_q[1].err !== 1'b0) begin
        n_fail++; $display("FAIL basic_read_rsp: got %h/%b want deadbeef/0", got_q[1].rdata, got_q[1].err);
      end
      n_cmp++; if (got_q[1].cyc - exp_q[1].cyc != RD_LAT) begin
        n_fail++; $display("FAIL basic_latency: got %0d want %0d", got_q[1].cyc - exp_q[1].cyc, RD_LAT);
      end
    end
  endtask

  task automatic test_partial();
    logic acc;
    exp_q.delete();
    got_q.delete();
    drive(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b1, acc);
    drive(1'b1, 1'b1, 32'h20, 32'h11223344, 4'h5, 1'b1, acc);
    drive(1'b1, 1'b0, 32'h20, '0, '0, 1'b1, acc);
    drive(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, acc);
    drive(1'b1, 1'b0, 32'h20, '0, '0, 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() != 5) begin
      n_fail++; $display("FAIL partial_count: got %0d responses want 5", got_q.size());
    end else begin
      n_cmp++; if (got_q[2].rdata !== 32'hDE22BE44) begin
        n_fail++; $display("FAIL partial_merge: got %h want de22be44", got_q[2].rdata);
      end
      n_cmp++; if (got_q[4].rdata !== 32'hDE22BE44) begin
        n_fail++; $display("FAIL partial_be0_noop: got %h want de22be44", got_q[4].rdata);
      end
      n_cmp++; if (got_q[3].rdata !== 32'h0 || got_q[3].err !== 1'b0) begin
        n_fail++; $display("FAIL partial_be0_rsp: got %h/%b want 00000000/0", got_q[3].rdata, got_q[3].err);
      end
    end
  endtask

  task automatic test_errors();
    logic acc;
    logic [31:0] last_word;
    last_word = 32'(DEPTH * 4 - 4);
    exp_q.delete();
    got_q.delete();
    drive(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1'b1, acc);
    drive(1'b1, 1'b0, 32'h2, '0, '0, 1'b1, acc);
    drive(1'b1, 1'b0, 32'(DEPTH * 4), '0, '0, 1'b1, acc);
    drive(1'b1, 1'b1, 32'h2, 32'h0, 4'hF, 1'b1, acc);
    drive(1'b1, 1'b1, 32'(DEPTH * 4), 32'h0, 4'hF, 1'b1, acc);
    drive(1'b1, 1'b1, last_word, 32'h5A5A1234, 4'hF, 1'b1, acc);
    drive(1'b1, 1'b0, last_word, '0, '0, 1'b1, acc);
    drive(1'b1, 1'b0, 32'h0, '0, '0, 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() != 8) begin
      n_fail++; $display("FAIL err_count: got %0d responses want 8", got_q.size());
    end else begin
      n_cmp++; if (got_q[1].err !== 1'b1 || got_q[1].rdata !== 32'h0) begin
        n_fail++; $display("FAIL err_unaligned: got %h/%b want 00000000/1", got_q[1].rdata, got_q[1].err);
      end
      n_cmp++; if (got_q[2].err !== 1'b1 || got_q[2].rdata !== 32'h0) begin
        n_fail++; $display("FAIL err_range: got %h/%b want 00000000/1", got_q[2].rdata, got_q[2].err);
      end
      n_cmp++; if (got_q[6].err !== 1'b0 || got_q[6].rdata !== 32'h5A5A1234) begin
        n_fail++; $display("FAIL err_last_word: got %h/%b want 5a5a1234/0", got_q[6].rdata, got_q[6].err);
      end
      n_cmp++; if (got_q[7].err !== 1'b0 || got_q[7].rdata !== 32'hA5A5A5A5) begin
        n_fail++; $display("FAIL err_mem_unchanged: got %h/%b want a5a5a5a5/0", got_q[7].rdata, got_q[7].err);
      end
      foreach (exp_q[i]) begin
        n_cmp++; if (got_q[i].rdata !== exp_q[i].rdata || got_q[i].err !== exp_q[i].err) begin
          n_fail++; $display("FAIL err_rsp[%0d]: got %h/%b want %h/%b", i, got_q[i].rdata,
                             got_q[i].err, exp_q[i].rdata, exp_q[i].err);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic        acc;
    logic [31:0] addrs [4];
    int          n_acc;
    int          late_acc;
    logic        held;
    logic [31:0] held_data;
    addrs[0] = 32'h10;
    addrs[1] = 32'h20;
    addrs[2] = 32'h0;
    addrs[3] = 32'h2;
    exp_q.delete();
    got_q.delete();
    n_acc    = 0;
    late_acc = 0;
    held     = 1'b0;
    held_data = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, addrs[i % 4], '0, '0, 1'b0, acc);
      if (acc) begin
        n_acc++;
        if (i > int'(RD_LAT)) late_acc++;
      end
      #1;
      if (held) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== held_data) begin
          n_fail++; $display("FAIL bp_hold: got %b/%h want 1/%h", rsp_valid, rsp_rdata, held_data);
        end
      end else if (rsp_valid === 1'b1) begin
        held      = 1'b1;
        held_data = rsp_rdata;
      end
    end
    n_cmp++; if (n_acc != RD_LAT + 1 || late_acc != 0) begin
      n_fail++; $display("FAIL bp_accepts: got %0d (%0d late) want %0d", n_acc, late_acc, RD_LAT + 1);
    end
    n_cmp++; if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low: got %b want 0", req_ready);
    end
    drain(40);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++; if (got_q[i].rdata !== exp_q[i].rdata || got_q[i].err !== exp_q[i].err) begin
          n_fail++; $display("FAIL bp_rsp[%0d]: got %h/%b want %h/%b", i, got_q[i].rdata,
                             got_q[i].err, exp_q[i].rdata, exp_q[i].err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   stalls;
    exp_q.delete();
    got_q.delete();
    stalls = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, REGION + 32'(4 * k), $urandom, 4'hF, 1'b1, acc);
      if (!acc) stalls++;
    end
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), pick_addr(), $urandom, 4'($urandom), 1'b1, acc);
      if (!acc) stalls++;
    end
    drain(50);
    n_cmp++; if (stalls != 0) begin
      n_fail++; $display("FAIL b2b_stalls: got %0d want 0", stalls);
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++; if (got_q[i].rdata !== exp_q[i].rdata || got_q[i].err !== exp_q[i].err ||
                     got_q[i].cyc - exp_q[i].cyc != RD_LAT) begin
          n_fail++; $display("FAIL b2b_rsp[%0d]: got %h/%b lat %0d want %h/%b lat %0d", i,
                             got_q[i].rdata, got_q[i].err, got_q[i].cyc - exp_q[i].cyc,
                             exp_q[i].rdata, exp_q[i].err, RD_LAT);
        end
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick_addr(), $urandom,
            4'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    end
    drain(100);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++; if (got_q[i].rdata !== exp_q[i].rdata || got_q[i].err !== exp_q[i].err) begin
          n_fail++; $display("FAIL rand_rsp[%0d]: got %h/%b want %h/%b", i, got_q[i].rdata,
                             got_q[i].err, exp_q[i].rdata, exp_q[i].err);
        end
      end
    end
  endtask

  task automatic test_xwrite();
    logic acc;
    logic probe;
    probe = 1'bx;
    if (!$isunknown(probe)) begin
      $display("note: two-state simulator, X-write counting not exercised");
      return;
    end
    exp_q.delete();
    got_q.delete();
    drive(1'b1, 1'b1, 32'h300, 32'hx, 4'hF, 1'b1, acc);
    drain(20);
    n_cmp++; if (xwr_cnt !== 8'd1) begin
      n_fail++; $display("FAIL xwr_first: got %0d want 1", xwr_cnt);
    end
    for (int i = 0; i < 299; i++) drive(1'b1, 1'b1, 32'h300, 32'hx, 4'hF, 1'b1, acc);
    drain(20);
    n_cmp++; if (xwr_cnt !== 8'd255) begin
      n_fail++; $display("FAIL xwr_saturate: got %0d want 255", xwr_cnt);
    end
    n_cmp++; if (got_q.size() != 300) begin
      n_fail++; $display("FAIL xwr_count: got %0d responses want 300", got_q.size());
    end
  endtask

  task automatic test_reset_midop();
    logic acc;
    exp_q.delete();
    got_q.delete();
    drive(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, acc);
    drain(20);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h40, '0, '0, 1'b0, acc);
    n_cmp++; if (exp_q.size() != 4) begin
      n_fail++; $display("FAIL midop_outstanding: got %0d accepts want 4", exp_q.size());
    end
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_wdata = 32'h0BAD0BAD;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_flush: got rsp_valid %b want 0", rsp_valid);
    end
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midop_ready: got %b want 1", req_ready);
    end
    exp_q.delete();
    got_q.delete();
    repeat (8) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    n_cmp++; if (got_q.size() != 0) begin
      n_fail++; $display("FAIL midop_no_rsp: got %0d responses want 0", got_q.size());
    end
    drive(1'b1, 1'b0, 32'h40, '0, '0, 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() != 1 || got_q[0].rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL midop_persist: got %0d rsp, data %h want 1 rsp, cafef00d",
                         got_q.size(), (got_q.size() > 0) ? got_q[0].rdata : 32'h0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_xwrite();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
